// File: rtl/feeder_pkg.sv
// Shared definitions for the systolic-row FIFO feeder: default widths and FSM encoding.
package feeder_pkg;

    localparam int DW_DEF   = 16;
    localparam int LENW_DEF = 8;
    localparam int SKW_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SKEW = 3'd1,
        ST_PUSH = 3'd2,
        ST_PAD  = 3'd3,
        ST_DONE = 3'd4
    } feeder_st_t;

endpackage

// File: rtl/feeder_dncnt.sv
// Loadable down-counter that holds at zero; load has priority over decrement.
module feeder_dncnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fifo_feeder.sv
// Write-side sequencer for one systolic-row FIFO: skewed start, len-word burst, ff/is stalls.
// Optional zero padding after the burst (row end alignment) is built when FEEDER_PAD_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SKEW  | counting down the row skew before the first push
// PUSH  | forwarding host words into the FIFO
// PAD   | pushing zero words so every row finishes together (FEEDER_PAD_EN only)
// DONE  | one-cycle completion pulse
module fifo_feeder
    import feeder_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int LENW = LENW_DEF,
    parameter int SKW  = SKW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clr,
    input  logic [LENW-1:0] len,
    input  logic [SKW-1:0]  skew,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    input  logic            is,
    input  logic            ff,
    output logic            we,
    output logic [DW-1:0]   din,
    output logic            busy,
    output logic            done
);

    feeder_st_t st, st_nxt;

    logic            idle_start;
    logic            we_data;
    logic            last_push;

    logic [LENW-1:0] rem;
    logic [LENW-1:0] rem_val;
    logic            rem_load, rem_dec, rem_zero, rem_one;

    logic [SKW-1:0]  skc;
    logic            skc_dec, skc_zero, skc_one;

    assign idle_start = (st == ST_IDLE) && start;
    assign we_data    = (st == ST_PUSH) && !ff && !is && in_valid;
    assign last_push  = we_data && rem_one;

    // clr wins over a simultaneous start, leaving rem cleared
    assign rem_load = clr || idle_start;
    assign rem_val  = clr ? '0 : len;
    assign rem_dec  = we_data && !rem_zero;
    assign rem_one  = (rem == LENW'(1));

    assign skc_dec  = (st == ST_SKEW) && !is;
    assign skc_one  = (skc == SKW'(1));

    feeder_dncnt #(.W(LENW)) u_rem (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rem_load),
        .load_val (rem_val),
        .dec      (rem_dec),
        .cnt      (rem),
        .zero     (rem_zero)
    );

    feeder_dncnt #(.W(SKW)) u_skc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (idle_start),
        .load_val (skew),
        .dec      (skc_dec),
        .cnt      (skc),
        .zero     (skc_zero)
    );

`ifdef FEEDER_PAD_EN
    logic [SKW-1:0] skew_lat;
    logic [SKW-1:0] pad_cnt;
    logic [SKW-1:0] pad_load;
    logic           pad_zero, pad_one, we_pad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_lat <= '0;
        end else if (idle_start) begin
            skew_lat <= skew;
        end
    end

    // pad = max skew - own skew, so skew + pad is the same for every row
    assign pad_load = {SKW{1'b1}} - skew_lat;
    assign pad_one  = (pad_cnt == SKW'(1));
    assign we_pad   = (st == ST_PAD) && !ff && !is && !pad_zero;

    feeder_dncnt #(.W(SKW)) u_pad (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (last_push),
        .load_val (pad_load),
        .dec      (we_pad),
        .cnt      (pad_cnt),
        .zero     (pad_zero)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        in_ready = 1'b0;
        we       = 1'b0;
        din      = '0;
        busy     = (st != ST_IDLE);
        done     = 1'b0;

        case (st)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        st_nxt = ST_DONE;
                    end else if (skew == '0) begin
                        st_nxt = ST_PUSH;
                    end else begin
                        st_nxt = ST_SKEW;
                    end
                end
            end
            ST_SKEW: begin
                if (!is && (skc_one || skc_zero)) begin
                    st_nxt = ST_PUSH;
                end
            end
            ST_PUSH: begin
                in_ready = !ff && !is;
                we       = we_data;
                din      = in_data;
                if (last_push) begin
`ifdef FEEDER_PAD_EN
                    // a row with maximum skew needs no padding, so skip PAD entirely
                    st_nxt = (pad_load == '0) ? ST_DONE : ST_PAD;
`else
                    st_nxt = ST_DONE;
`endif
                end
            end
`ifdef FEEDER_PAD_EN
            ST_PAD: begin
                we = we_pad;
                if (pad_zero || (we_pad && pad_one)) begin
                    st_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done   = 1'b1;
                st_nxt = ST_IDLE;
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase

        if (clr) begin
            st_nxt = ST_IDLE;
        end
    end

endmodule
